io_port_responder: RTL and testbench

Memory-mapped I/O responder sitting on the CPU's 16-bit-address / 32-bit-data memory bus, alongside main memory. It owns the board LEDs and switches and a free-running cycle timer. It synchronizes and debounces the four switches, and latches rising edges into sticky flags the CPU clears by write-1. Read data is registered, giving single-cycle synchronous-read timing; the top level muxes its `data_out` into the CPU read path when `hit` is high.

---
 rtl/io_port_responder.sv | 91 +++++++++
 tb/tb_io_port_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// Memory-mapped I/O responder: LED register, debounced switches with sticky
// rise flags (write-1-to-clear) and a free-running 32-bit timer.
module io_port_responder #(
    parameter logic [15:0] BASE            = 16'hFFF0,
    parameter int          DEBOUNCE_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic [31:0] data_in,
    input  logic        we,
    input  logic [3:0]  switches,
    output logic [31:0] data_out,
    output logic        hit,
    output logic [3:0]  LEDs
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         r_sync1, r_sync2, r_deb, r_flags, r_leds;
    logic [3:0][CW-1:0] r_cnt;
    logic [31:0]        r_timer, r_dout;
    logic               r_hit;

    logic        w_dec, w_wr;
    logic [1:0]  w_off;
    logic [3:0]  w_flip, w_rise, w_clr;
    logic [31:0] w_rdata;

    assign w_dec = (address[15:2] == BASE[15:2]);
    assign w_off = address[1:0];
    assign w_wr  = we & w_dec;
    assign w_clr = (w_wr && w_off == 2'd2) ? data_in[3:0] : 4'h0;

    // A flip happens on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_comb begin
        w_flip = 4'h0;
        for (int i = 0; i < 4; i++)
            w_flip[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == CNT_MAX);
    end
    assign w_rise = w_flip & r_sync2;

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            2'd0: w_rdata = {28'h0, r_leds};
            2'd1: w_rdata = {28'h0, r_deb};
            2'd2: w_rdata = {28'h0, r_flags};
            2'd3: w_rdata = r_timer;
            default: w_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
            r_flags <= '0;
            r_leds  <= '0;
            r_timer <= '0;
            r_dout  <= '0;
            r_hit   <= 1'b0;
        end else begin
            r_sync1 <= switches;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_flip[i]) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            if (w_wr && w_off == 2'd0)
                r_leds <= data_in[3:0];
            // New rise is OR'd after the clear so it survives a same-cycle W1C.
            r_flags <= (r_flags & ~w_clr) | w_rise;
            r_timer <= (w_wr && w_off == 2'd3) ? data_in : r_timer + 32'd1;
            r_hit   <= w_dec;
            r_dout  <= (w_dec && !we) ? w_rdata : 32'h0;
        end
    end

    assign data_out = r_dout;
    assign hit      = r_hit;
    assign LEDs     = r_leds;
endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder with DEBOUNCE_CYCLES=4.
module tb_io_port_responder;
    localparam int DC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0;
    logic [31:0] data_in = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  switches = 4'h0;
    logic [31:0] data_out;
    logic        hit;
    logic [3:0]  LEDs;

    int n_vec = 0;
    int n_err = 0;

    io_port_responder #(.BASE(16'hFFF0), .DEBOUNCE_CYCLES(DC)) dut (
        .clock(clock), .reset(reset), .address(address), .data_in(data_in),
        .we(we), .switches(switches), .data_out(data_out), .hit(hit), .LEDs(LEDs)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic w, input logic [31:0] d);
        address = a;
        we      = w;
        data_in = d;
    endtask

    // Switch 2 rises before edge 1; debounced flips on edge 1+1+DC, visible in a read one edge later.
    task automatic watch_rise(input string tag);
        bus(16'hFFF1, 1'b0, 32'h0);
        switches = 4'h4;
        for (int j = 1; j <= 10; j++) begin
            step();
            chk(tag, data_out, (j >= DC + 3) ? 32'h4 : 32'h0);
        end
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        chk("rst_dout", data_out, 32'h0);
        chk("rst_hit",  {31'h0, hit}, 32'h0);
        chk("rst_leds", {28'h0, LEDs}, 32'h0);
        #10 reset = 1'b1;
        step();

        for (int i = 0; i < 3; i++) begin
            bus(16'hFFF0 + 16'(i), 1'b0, 32'h0);
            step();
            chk("rd_hit", {31'h0, hit}, 32'h1);
            chk("rd_zero", data_out, 32'h0);
        end
        bus(16'hFFF3, 1'b0, 32'h0);
        step();
        chk("rd_timer_hit", {31'h0, hit}, 32'h1);
        bus(16'h0010, 1'b0, 32'h0);
        step();
        chk("unmapped_hit", {31'h0, hit}, 32'h0);
        chk("unmapped_dout", data_out, 32'h0);

        bus(16'hFFF0, 1'b1, 32'hFFFFFFA5);
        step();
        chk("led_wr", {28'h0, LEDs}, 32'h5);
        chk("wr_dout", data_out, 32'h0);
        chk("wr_hit", {31'h0, hit}, 32'h1);
        bus(16'hFFF0, 1'b0, 32'h0);
        step();
        chk("led_rd", data_out, 32'h5);

        // 3-cycle glitch must not reach the debounced value.
        switches = 4'h4;
        for (int j = 0; j < 3; j++) step();
        switches = 4'h0;
        for (int j = 0; j < 8; j++) step();
        bus(16'hFFF1, 1'b0, 32'h0);
        step();
        chk("glitch_deb", data_out, 32'h0);
        bus(16'hFFF2, 1'b0, 32'h0);
        step();
        chk("glitch_flag", data_out, 32'h0);

        watch_rise("rise_deb");
        bus(16'hFFF2, 1'b0, 32'h0);
        step();
        chk("rise_flag", data_out, 32'h4);
        bus(16'hFFF1, 1'b1, 32'hF);
        step();
        bus(16'hFFF1, 1'b0, 32'h0);
        step();
        chk("ro_deb", data_out, 32'h4);

        // Release, then re-raise with a W1C landing on the flip edge.
        switches = 4'h0;
        for (int j = 0; j < 10; j++) step();
        bus(16'hFFF2, 1'b0, 32'h0);
        step();
        chk("fall_flag_kept", data_out, 32'h4);
        switches = 4'h4;
        for (int j = 1; j <= DC + 1; j++) step();
        bus(16'hFFF2, 1'b1, 32'h4);
        step();
        bus(16'hFFF2, 1'b0, 32'h0);
        step();
        chk("set_wins", data_out, 32'h4);
        bus(16'hFFF2, 1'b1, 32'h4);
        step();
        bus(16'hFFF2, 1'b0, 32'h0);
        step();
        chk("w1c", data_out, 32'h0);

        bus(16'hFFF3, 1'b1, 32'hFFFFFFFE);
        step();
        bus(16'hFFF3, 1'b0, 32'h0);
        step();
        chk("timer0", data_out, 32'hFFFFFFFE);
        step();
        chk("timer1", data_out, 32'hFFFFFFFF);
        step();
        chk("timer_wrap", data_out, 32'h0);

        // Async reset mid-debounce.
        bus(16'hFFF0, 1'b1, 32'h5);
        switches = 4'h0;
        step();
        bus(16'hFFF0, 1'b0, 32'h0);
        for (int j = 0; j < 10; j++) step();
        switches = 4'h4;
        for (int j = 0; j < 3; j++) step();
        chk("pre_rst_dout", data_out, 32'h5);
        chk("pre_rst_hit", {31'h0, hit}, 32'h1);
        #3 reset = 1'b0;
        #1;
        chk("arst_leds", {28'h0, LEDs}, 32'h0);
        chk("arst_dout", data_out, 32'h0);
        chk("arst_hit", {31'h0, hit}, 32'h0);
        #2 reset = 1'b1;
        watch_rise("post_rst_deb");
        bus(16'hFFF2, 1'b0, 32'h0);
        step();
        chk("post_rst_flag", data_out, 32'h4);
        chk("post_rst_leds", {28'h0, LEDs}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
